// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-port round-robin arbiter with hold-until-done grants and a dead release cycle.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles (pulses expired).
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       r,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       expired
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t state, state_nx;
   logic [1:0] ptr, ptr_nx, gnt_id_nx, off, win;
   logic [3:0] gnt_nx, rot;
   logic [7:0] dbl;
   logic busy_nx, expired_nx, tmo, leave;
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("MAX_HOLD out of range 1..255");
   end
   // rotate so bit 0 is the highest-priority requester (the one at ptr)
   assign dbl = {req, req};
   assign rot = dbl[ptr +: 4];
   assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   assign win = ptr + off;
`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt;
   assign tmo = cnt == 8'(MAX_HOLD - 1);
   always_ff @(posedge clk or posedge r)
      if (r) cnt <= '0;
      else cnt <= (state == GRANT) ? cnt + 8'd1 : 8'd0;
`else
   assign tmo = 1'b0;
`endif
   assign leave = done | ~req[gnt_id] | tmo;
   always_comb begin
      state_nx = state;
      ptr_nx = ptr;
      gnt_nx = gnt;
      gnt_id_nx = gnt_id;
      busy_nx = busy;
      expired_nx = 1'b0;
      case (state)
         IDLE: if (|req) begin
            state_nx = GRANT;
            gnt_nx = 4'b0001 << win;
            gnt_id_nx = win;
            busy_nx = 1'b1;
         end
         GRANT: if (leave) begin
            state_nx = RELEASE;
            gnt_nx = '0;
            busy_nx = 1'b0;
            ptr_nx = gnt_id + 2'd1;
            expired_nx = tmo & ~done & req[gnt_id];
         end
         default: begin
            state_nx = IDLE;
            gnt_nx = '0;
            busy_nx = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge r)
      if (r) begin
         state <= IDLE;
         ptr <= '0;
         gnt <= '0;
         gnt_id <= '0;
         busy <= 1'b0;
         expired <= 1'b0;
      end else begin
         state <= state_nx;
         ptr <= ptr_nx;
         gnt <= gnt_nx;
         gnt_id <= gnt_id_nx;
         busy <= busy_nx;
         expired <= expired_nx;
      end
endmodule
